ysyx_040066_dmem_slave: RTL and testbench

Memory-side responder for the core's data port: it receives the load/store requests the CPU M stage issues and answers them with `data_valid`, `data_Rd` and `data_error`. It is backed by a word-addressed on-chip scratchpad with a programmable response latency, and it is used as the data memory in standalone and simulation builds. It checks address range and alignment, and it handles a request withdrawn by the core (trap flush) without side effects.

---
 rtl/ysyx_040066_dmem_slave.sv | 209 ++++++++++++++++++++
 tb/tb_ysyx_040066_dmem_slave.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040066_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_040066_dmem_slave
// Purpose  : Data-port memory responder. Accepts one load/store request from
//            the core, waits a programmable latency and answers with a
//            single-cycle registered response. Backed by a word-addressed
//            64-bit scratchpad. Checks range/alignment and drops requests
//            that the core withdraws before the response.
// Ports    : clk, rst (async, active-high)
//            MemRd, MemWr, addr, wr_len, wr_mask, data_Wr : request side
//            data_valid, data_error, data_Rd              : response side
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_040066_dmem_slave #(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [63:0] addr,
  input  logic [2:0]  wr_len,
  input  logic [7:0]  wr_mask,
  input  logic [63:0] data_Wr,
  output logic        data_valid,
  output logic        data_error,
  output logic [63:0] data_Rd
);

  localparam int              CW       = $clog2(LATENCY) + 1;
  localparam int              AW       = $clog2(DEPTH);
  localparam logic [63:0]     SPAN     = 64'(DEPTH) * 64'd8;
  localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [63:0]   addr_q, addr_d;
  logic [2:0]    len_q, len_d;
  logic [7:0]    mask_q, mask_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic [63:0]   rdata_q, rdata_d;

  logic [63:0]   mem [DEPTH];

  logic          req;
  logic          enter_resp;
  logic          mem_we;

  // Access being completed at the edge into RESP. With LATENCY == 1 the
  // transition comes straight from IDLE, so the live inputs are used;
  // otherwise the copy latched at acceptance is used.
  logic          acc_rd, acc_wr;
  logic [63:0]   acc_addr;
  logic [2:0]    acc_len;
  logic [7:0]    acc_mask;
  logic [63:0]   acc_wdata;
  logic [63:0]   offset;
  logic          misaligned, out_of_range, acc_error;
  logic [AW-1:0] word_idx;

  assign req = MemRd | MemWr;

  always_comb begin
    if (state_q == S_IDLE) begin
      acc_rd    = MemRd;
      acc_wr    = MemWr;
      acc_addr  = addr;
      acc_len   = wr_len;
      acc_mask  = wr_mask;
      acc_wdata = data_Wr;
    end else begin
      acc_rd    = rd_q;
      acc_wr    = wr_q;
      acc_addr  = addr_q;
      acc_len   = len_q;
      acc_mask  = mask_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    misaligned = 1'b0;
    case (acc_len)
      3'd1:    misaligned = acc_addr[0];
      3'd2:    misaligned = |acc_addr[1:0];
      3'd3:    misaligned = |acc_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign offset       = acc_addr - BASE;
  assign out_of_range = (acc_addr < BASE) || (offset >= SPAN);
  assign acc_error    = (acc_rd && acc_wr) || (acc_len > 3'd3) || misaligned || out_of_range;
  assign word_idx     = offset[AW+2:3];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and request capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rd_d    = MemRd;
          wr_d    = MemWr;
          addr_d  = addr;
          len_d   = wr_len;
          mask_d  = wr_mask;
          wdata_d = data_Wr;
          cnt_d   = CNT_INIT;
          state_d = (CNT_INIT == '0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          // Core withdrew the request (trap flush): drop it silently.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        // The request still visible here is the one being acknowledged.
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output / commit logic. RESP is only ever entered from IDLE or WAIT, so
  // state_d == S_RESP marks the edge at which the access completes.
  always_comb begin
    enter_resp = (state_d == S_RESP);
    valid_d    = enter_resp;
    error_d    = enter_resp && acc_error;
    rdata_d    = '0;
    if (enter_resp && !acc_error && acc_rd) begin
      rdata_d = mem[word_idx];
    end
    // rst gating keeps a write from landing on an edge that reset is holding.
    mem_we = enter_resp && !acc_error && acc_wr && !rst;
  end

  // Scratchpad: contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_we && acc_mask[i]) begin
        mem[word_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign data_valid = valid_q;
  assign data_error = error_q;
  assign data_Rd    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_040066_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_040066_dmem_slave
// Purpose  : Self-checking bench for ysyx_040066_dmem_slave. Three instances
//            with LATENCY = 2, 3 and 1 share clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_040066_dmem_slave;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        mrd   [3];
  logic        mwr   [3];
  logic [63:0] maddr [3];
  logic [2:0]  mlen  [3];
  logic [7:0]  mmask [3];
  logic [63:0] mwd   [3];
  logic        dv    [3];
  logic        de    [3];
  logic [63:0] drd   [3];

  int tests = 0;
  int fails = 0;
  int vcount [3] = '{0, 0, 0};
  logic [63:0] mdl [16];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dv[k] === 1'b1) vcount[k]++;
    end
  end

  ysyx_040066_dmem_slave #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .MemRd(mrd[0]), .MemWr(mwr[0]), .addr(maddr[0]),
    .wr_len(mlen[0]), .wr_mask(mmask[0]), .data_Wr(mwd[0]),
    .data_valid(dv[0]), .data_error(de[0]), .data_Rd(drd[0]));

  ysyx_040066_dmem_slave #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .MemRd(mrd[1]), .MemWr(mwr[1]), .addr(maddr[1]),
    .wr_len(mlen[1]), .wr_mask(mmask[1]), .data_Wr(mwd[1]),
    .data_valid(dv[1]), .data_error(de[1]), .data_Rd(drd[1]));

  ysyx_040066_dmem_slave #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .MemRd(mrd[2]), .MemWr(mwr[2]), .addr(maddr[2]),
    .wr_len(mlen[2]), .wr_mask(mmask[2]), .data_Wr(mwd[2]),
    .data_valid(dv[2]), .data_error(de[2]), .data_Rd(drd[2]));

  // Reference rule for a failed access, straight from the address/size rules.
  function automatic bit model_err(bit rd, bit wr, logic [63:0] a, logic [2:0] len);
    if (rd && wr) return 1'b1;
    if (len > 3'd3) return 1'b1;
    if ((a % (64'd1 << len)) != 64'd0) return 1'b1;
    if (a < BASE || a >= BASE + 64'(DEPTH) * 64'd8) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs(input int k);
    mrd[k] = 1'b0; mwr[k] = 1'b0; maddr[k] = '0;
    mlen[k] = '0; mmask[k] = '0; mwd[k] = '0;
  endtask

  // Present one request from the start of a cycle, hold it until data_valid,
  // then drop it. lat is the response cycle index, -1 on timeout.
  task automatic access(input int k, input bit rd, input bit wr, input logic [63:0] a,
                        input logic [2:0] len, input logic [7:0] m, input logic [63:0] d,
                        output int lat, output bit err, output logic [63:0] rdat);
    lat = -1; err = 1'b0; rdat = '0;
    @(posedge clk); #1;
    mrd[k] = rd; mwr[k] = wr; maddr[k] = a; mlen[k] = len; mmask[k] = m; mwd[k] = d;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dv[k] === 1'b1) begin
        lat = c; err = de[k]; rdat = drd[k];
        break;
      end
    end
    @(posedge clk); #1;
    idle_inputs(k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) idle_inputs(k);
    repeat (2) @(posedge clk);
    #3;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({dv[k], de[k], drd[k]} !== 66'd0) begin
        fails++;
        $display("FAIL reset_state[%0d]: got v=%b e=%b rd=%h want all zero", k, dv[k], de[k], drd[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; bit err; logic [63:0] rdat;
    access(0, 0, 1, BASE + 64'h10, 3'd3, 8'hFF, 64'h1122334455667788, lat, err, rdat);
    tests++;
    if (lat !== 2 || err !== 1'b0) begin
      fails++;
      $display("FAIL wr_resp: got lat=%0d err=%b want lat=2 err=0", lat, err);
    end
    access(0, 1, 0, BASE + 64'h10, 3'd3, 8'h00, 64'h0, lat, err, rdat);
    tests++;
    if (lat !== 2 || err !== 1'b0 || rdat !== 64'h1122334455667788) begin
      fails++;
      $display("FAIL rd_back: got lat=%0d err=%b data=%h want lat=2 err=0 data=1122334455667788", lat, err, rdat);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] got;
    bit seen;
    seen = 1'b0; got = '0;
    @(posedge clk); #1;
    mrd[0] = 1'b1; maddr[0] = BASE + 64'h10; mlen[0] = 3'd3;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dv[0] === 1'b1) begin seen = 1'b1; got = drd[0]; break; end
    end
    tests++;
    if (!seen || got !== 64'h1122334455667788) begin
      fails++;
      $display("FAIL pre_reset_read: got seen=%b data=%h want data=1122334455667788", seen, got);
    end
    // Mid-cycle reset, no clock edge before the check.
    #1; rst = 1'b1; mrd[0] = 1'b0;
    #1;
    tests++;
    if ({dv[0], de[0], drd[0]} !== 66'd0) begin
      fails++;
      $display("FAIL async_reset: got v=%b e=%b rd=%h want all zero", dv[0], de[0], drd[0]);
    end
    #1; rst = 1'b0;
    @(posedge clk); #1;
    idle_inputs(0);
  endtask

  task automatic test_byte_write();
    int lat; bit err; logic [63:0] rdat;
    access(0, 0, 1, BASE + 64'h12, 3'd0, 8'h04, 64'h0000_0000_00AB_0000, lat, err, rdat);
    tests++;
    if (lat !== 2 || err !== 1'b0 || rdat !== 64'd0) begin
      fails++;
      $display("FAIL byte_wr_resp: got lat=%0d err=%b data=%h want 2/0/0", lat, err, rdat);
    end
    access(0, 1, 0, BASE + 64'h10, 3'd3, 8'h00, 64'h0, lat, err, rdat);
    tests++;
    if (rdat !== 64'h11223344_55AB7788 || err !== 1'b0) begin
      fails++;
      $display("FAIL byte_wr_read: got err=%b data=%h want err=0 data=1122334455ab7788", err, rdat);
    end
  endtask

  task automatic test_errors();
    int lat; bit err; logic [63:0] rdat;
    access(0, 1, 0, BASE - 64'd8, 3'd3, 8'h00, 64'h0, lat, err, rdat);
    tests++;
    if (lat !== 2 || err !== 1'b1 || rdat !== 64'd0) begin
      fails++;
      $display("FAIL err_below_base: got lat=%0d err=%b data=%h want 2/1/0", lat, err, rdat);
    end
    access(0, 0, 1, BASE + 64'h12, 3'd2, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, lat, err, rdat);
    tests++;
    if (lat !== 2 || err !== 1'b1 || rdat !== 64'd0) begin
      fails++;
      $display("FAIL err_misaligned: got lat=%0d err=%b data=%h want 2/1/0", lat, err, rdat);
    end
    access(0, 1, 0, BASE + 64'h10, 3'd3, 8'h00, 64'h0, lat, err, rdat);
    tests++;
    if (rdat !== 64'h11223344_55AB7788 || err !== 1'b0) begin
      fails++;
      $display("FAIL err_no_write: got err=%b data=%h want err=0 data=1122334455ab7788", err, rdat);
    end
    access(0, 1, 1, BASE + 64'h10, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, lat, err, rdat);
    tests++;
    if (lat !== 2 || err !== 1'b1 || rdat !== 64'd0) begin
      fails++;
      $display("FAIL err_rd_and_wr: got lat=%0d err=%b data=%h want 2/1/0", lat, err, rdat);
    end
  endtask

  task automatic test_random();
    logic [63:0] a, d, exp_rd, rdat, off;
    logic [2:0]  len;
    logic [7:0]  m;
    bit rd, wr, e, err;
    int lat, w, r;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      access(0, 0, 1, BASE + 64'(i * 8), 3'd3, 8'hFF, d, lat, err, rdat);
      mdl[i] = d;
      tests++;
      if (lat !== 2 || err !== 1'b0) begin
        fails++;
        $display("FAIL rand_init[%0d]: got lat=%0d err=%b want lat=2 err=0", i, lat, err);
      end
    end
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      rd = (r == 0) || (r >= 1 && r <= 4);
      wr = (r == 0) || (r >= 5);
      len = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      m = 8'($urandom);
      d = {$urandom, $urandom};
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        a = BASE - 64'd8 * 64'($urandom_range(1, 4)) + 64'($urandom_range(0, 7));
      end else if (r == 1) begin
        a = BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 31));
      end else begin
        off = 64'($urandom_range(0, 7));
        if ($urandom_range(0, 2) != 0 && len <= 3'd3) off = off - (off % (64'd1 << len));
        a = BASE + 64'd8 * 64'($urandom_range(0, 15)) + off;
      end
      e = model_err(rd, wr, a, len);
      exp_rd = '0;
      if (!e) begin
        w = int'((a - BASE) / 64'd8);
        if (rd) begin
          exp_rd = mdl[w];
        end else begin
          for (int i = 0; i < 8; i++) if (m[i]) mdl[w][8*i +: 8] = d[8*i +: 8];
        end
      end
      access(0, rd, wr, a, len, m, d, lat, err, rdat);
      tests++;
      if (lat !== 2 || err !== e || rdat !== exp_rd) begin
        fails++;
        $display("FAIL rand[%0d] rd=%b wr=%b a=%h len=%0d: got lat=%0d err=%b data=%h want lat=2 err=%b data=%h",
                 n, rd, wr, a, len, lat, err, rdat, e, exp_rd);
      end
    end
  endtask

  task automatic test_abort();
    int lat, v0; bit err; logic [63:0] rdat;
    access(1, 0, 1, BASE + 64'h10, 3'd3, 8'hFF, 64'hCAFE_F00D_1234_5678, lat, err, rdat);
    tests++;
    if (lat !== 3 || err !== 1'b0) begin
      fails++;
      $display("FAIL abort_setup: got lat=%0d err=%b want lat=3 err=0", lat, err);
    end
    // Withdrawal in cycle 1.
    v0 = vcount[1];
    @(posedge clk); #1;
    mwr[1] = 1'b1; maddr[1] = BASE + 64'h10; mlen[1] = 3'd3; mmask[1] = 8'hFF; mwd[1] = 64'h5555_AAAA_5555_AAAA;
    @(posedge clk); #1;
    idle_inputs(1);
    repeat (6) @(posedge clk);
    tests++;
    if (vcount[1] !== v0) begin
      fails++;
      $display("FAIL abort_no_valid: got %0d responses want 0", vcount[1] - v0);
    end
    access(1, 1, 0, BASE + 64'h10, 3'd3, 8'h00, 64'h0, lat, err, rdat);
    tests++;
    if (lat !== 3 || err !== 1'b0 || rdat !== 64'hCAFE_F00D_1234_5678) begin
      fails++;
      $display("FAIL abort_unchanged: got lat=%0d err=%b data=%h want lat=3 err=0 data=cafef00d12345678", lat, err, rdat);
    end
    // Reset pulse while in WAIT.
    v0 = vcount[1];
    @(posedge clk); #1;
    mwr[1] = 1'b1; maddr[1] = BASE + 64'h10; mlen[1] = 3'd3; mmask[1] = 8'hFF; mwd[1] = 64'h7777_0000_7777_0000;
    @(posedge clk); #2;
    rst = 1'b1; idle_inputs(1);
    #2; rst = 1'b0;
    repeat (6) @(posedge clk);
    tests++;
    if (vcount[1] !== v0) begin
      fails++;
      $display("FAIL rst_wait_no_valid: got %0d responses want 0", vcount[1] - v0);
    end
    access(1, 1, 0, BASE + 64'h10, 3'd3, 8'h00, 64'h0, lat, err, rdat);
    tests++;
    if (lat !== 3 || err !== 1'b0 || rdat !== 64'hCAFE_F00D_1234_5678) begin
      fails++;
      $display("FAIL rst_wait_recover: got lat=%0d err=%b data=%h want lat=3 err=0 data=cafef00d12345678", lat, err, rdat);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  vpat;
    logic [63:0] rd3;
    logic        e3;
    vpat = '0; rd3 = '0; e3 = 1'b1;
    @(posedge clk); #1;
    mwr[2] = 1'b1; maddr[2] = BASE + 64'h20; mlen[2] = 3'd3; mmask[2] = 8'hFF; mwd[2] = 64'h0BAD_C0DE_FEED_BEEF;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      vpat[c] = (dv[2] === 1'b1);
      if (c == 3) begin rd3 = drd[2]; e3 = de[2]; end
      @(posedge clk); #1;
      if (c == 1) begin
        mwr[2] = 1'b0; mrd[2] = 1'b1; mmask[2] = 8'h00; mwd[2] = 64'h0;
      end
      if (c == 3) idle_inputs(2);
    end
    tests++;
    if (vpat !== 7'b000_1010) begin
      fails++;
      $display("FAIL b2b_valid_cycles: got pattern %b want 0001010", vpat);
    end
    tests++;
    if ($countones(vpat) !== 2) begin
      fails++;
      $display("FAIL b2b_resp_count: got %0d want 2", $countones(vpat));
    end
    tests++;
    if (rd3 !== 64'h0BAD_C0DE_FEED_BEEF || e3 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_read_new: got err=%b data=%h want err=0 data=0badc0defeedbeef", e3, rd3);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_async_reset();
    test_byte_write();
    test_errors();
    test_abort();
    test_back_to_back();
    test_random();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
